pipe_hazard_ctl: RTL

PIPE_HAZARD_CTL -- requirements
Module: pipe_hazard_ctl

---
 rtl/pipe_hazard_ctl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctl.sv
// Hazard controller for a 5-stage pipeline: load-use interlock, branch redirect
// flushes, data-memory freeze with timeout FSM, and saturating perf counters.
module pipe_hazard_ctl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_RegWEn,
  input  logic             ex_pc_sel,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_timeout,
  output logic [1:0]       ctl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    TIMEOUT = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 32'd1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic             mem_timeout_r;
  logic             mem_stall_s;
  logic             load_use_s;
  logic [4:0]       en_s;   // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [1:0]       fl_s;   // {if_id, id_ex}

  assign mem_stall_s = dmem_req & ~dmem_ack;
  assign load_use_s  = ex_is_load & ex_RegWEn & (ex_rd != 5'd0) &
                       ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));

  // Enable/flush priority; reset holds the pipeline full of bubbles.
  always_comb begin
    en_s = 5'b11111;
    fl_s = 2'b00;
    if (rst) begin
      en_s = 5'b00000;
      fl_s = 2'b11;
    end else if (state_r == TIMEOUT) begin
      en_s = 5'b00000;
      fl_s = 2'b00;
    end else if (mem_stall_s) begin
      en_s = 5'b00000;
      fl_s = 2'b00;
    end else if (ex_pc_sel) begin
      en_s = 5'b11111;
      fl_s = 2'b11;
    end else if (load_use_s) begin
      en_s = 5'b00111;
      fl_s = 2'b01;
    end else begin
      en_s = 5'b11111;
      fl_s = 2'b00;
    end
  end

  // Next-state logic; the wait counter holds stalls completed before this cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (mem_stall_s) state_nxt_s = MEMWAIT;
        else             state_nxt_s = RUN;
      end
      MEMWAIT: begin
        if (!mem_stall_s)                 state_nxt_s = RUN;
        else if (wait_cnt_r >= WAIT_LAST) state_nxt_s = TIMEOUT;
        else                              state_nxt_s = MEMWAIT;
      end
      TIMEOUT: state_nxt_s = TIMEOUT;
      default: state_nxt_s = RUN;
    endcase
  end

  // State, sticky timeout flag, wait counter and saturating perf counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      mem_timeout_r <= 1'b0;
      wait_cnt_r    <= '0;
      stall_cnt_r   <= '0;
      flush_cnt_r   <= '0;
    end else begin
      state_r       <= state_nxt_s;
      mem_timeout_r <= (state_nxt_s == TIMEOUT);
      if (mem_stall_s && (state_r != TIMEOUT)) begin
        if (wait_cnt_r != CNT_MAX) wait_cnt_r <= wait_cnt_r + CNT_ONE;
        else                       wait_cnt_r <= wait_cnt_r;
      end else begin
        wait_cnt_r <= '0;
      end
      if (!en_s[4] && (state_r != TIMEOUT) && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (fl_s[1] && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign pc_en       = en_s[4];
  assign if_id_en    = en_s[3];
  assign id_ex_en    = en_s[2];
  assign ex_mem_en   = en_s[1];
  assign mem_wb_en   = en_s[0];
  assign if_id_flush = fl_s[1];
  assign id_ex_flush = fl_s[0];
  assign mem_timeout = mem_timeout_r;
  assign ctl_state   = state_r;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;

endmodule
